mio_bus_responder: RTL and testbench

Memory/IO bus responder that services the single-cycle CPU core's data-side requests (CPU_MIO strobe, MemRW direction, 32-bit address and write data) and returns read data with an MIO_ready handshake. It holds a word-addressed data RAM with a programmable wait-state count plus a small peripheral page (LED register, switch input, cycle counter). It sits between the CPU core and the board I/O as the far end of the CPU's memory interface.

---
 rtl/mio_bus_responder.sv | 146 ++++++++++++++
 tb/tb_mio_bus_responder.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mio_bus_responder.sv
// Data-side memory/IO responder for the single-cycle CPU core: a word RAM behind a
// fixed wait-state count plus an LED / switch / cycle-counter peripheral page.
module mio_bus_responder #(
  parameter int RAM_ADDR_W  = 10,
  parameter int WAIT_CYCLES = 2,
  parameter int LED_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CPU_MIO,
  input  logic             MemRW,
  input  logic [31:0]      Addr_in,
  input  logic [31:0]      Data_in,
  input  logic [LED_W-1:0] sw_in,
  output logic [31:0]      Data_out,
  output logic             MIO_ready,
  output logic [LED_W-1:0] led_out,
  output logic             bus_err,
  output logic [1:0]       state_o
);

  localparam int            CW        = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] WAIT_LOAD = CW'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

  // Handshake: the CPU raises CPU_MIO with MemRW/Addr_in/Data_in stable and holds
  // them until it sees the one-cycle MIO_ready pulse. Dropping CPU_MIO while the
  // access is still waiting aborts it with no side effects and no response.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  state_e           state_q;
  logic [CW-1:0]    wait_q;
  logic             ready_q;
  logic             err_q;
  logic [31:0]      data_q;
  logic [31:0]      cnt_q;
  logic [LED_W-1:0] led_q;
  logic [31:0]      mem [0:(1<<RAM_ADDR_W)-1];

  logic [RAM_ADDR_W-1:0] ram_idx;
  logic                  is_ram;
  logic                  is_sw;
  logic                  is_led;
  logic                  is_cnt;
  logic                  is_unmapped;
  logic                  commit;
  logic [31:0]           rd_data;
  logic                  unused_addr_bits;

  assign ram_idx          = Addr_in[RAM_ADDR_W+1:2];
  assign unused_addr_bits = ^{Addr_in[27:RAM_ADDR_W+2], Addr_in[1:0]};

  always_comb begin
    is_ram      = 1'b0;
    is_sw       = 1'b0;
    is_led      = 1'b0;
    is_cnt      = 1'b0;
    is_unmapped = 1'b0;
    unique case (Addr_in[31:28])
      4'h0:    is_ram = 1'b1;
      4'hE:    is_sw  = 1'b1;
      4'hF: begin
        is_led = ~Addr_in[2];
        is_cnt = Addr_in[2];
      end
      default: is_unmapped = 1'b1;
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    if (is_ram)      rd_data = mem[ram_idx];
    else if (is_sw)  rd_data = 32'(sw_in);
    else if (is_led) rd_data = 32'(led_q);
    else if (is_cnt) rd_data = cnt_q;
  end

  // The access takes effect on the edge that moves the FSM into RESP.
  assign commit = CPU_MIO &&
                  (((state_q == ST_IDLE) && (WAIT_CYCLES == 0)) ||
                   ((state_q == ST_WAIT) && (wait_q == '0)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
      ready_q <= 1'b0;
      data_q  <= 32'h0;
      led_q   <= '0;
      cnt_q   <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      ready_q <= 1'b0;
      cnt_q   <= cnt_q + 32'd1;
      unique case (state_q)
        ST_IDLE: begin
          if (CPU_MIO) begin
            if (WAIT_CYCLES == 0) begin
              state_q <= ST_RESP;
              ready_q <= 1'b1;
            end else begin
              state_q <= ST_WAIT;
              wait_q  <= WAIT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (!CPU_MIO) begin
            state_q <= ST_IDLE;
          end else if (wait_q == '0) begin
            state_q <= ST_RESP;
            ready_q <= 1'b1;
          end else begin
            wait_q <= wait_q - CW'(1);
          end
        end
        ST_RESP: state_q <= ST_IDLE;
        default: state_q <= ST_IDLE;
      endcase
      if (commit) begin
        if (MemRW) begin
          if (is_led) led_q <= Data_in[LED_W-1:0];
          if (is_cnt) cnt_q <= Data_in;
        end else begin
          data_q <= rd_data;
        end
        if (is_unmapped) err_q <= 1'b1;
      end
    end
  end

  // RAM has no reset; its contents are undefined until written.
  always_ff @(posedge clk) begin
    if (commit && MemRW && is_ram) mem[ram_idx] <= Data_in;
  end

  assign Data_out  = data_q;
  assign MIO_ready = ready_q;
  assign led_out   = led_q;
  assign bus_err   = err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_mio_bus_responder.sv
// Randomized bench for mio_bus_responder against an address-map reference model;
// a second instance built with zero wait states covers the single-cycle response.
module tb_mio_bus_responder;

  localparam int W  = 2;
  localparam int RW = 10;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        cpu_mio, mem_rw;
  logic [31:0] addr, wdata;
  logic [15:0] sw;
  logic [31:0] dout;
  logic        ready;
  logic [15:0] led;
  logic        err;
  logic [1:0]  st;

  logic        d0_cpu, d0_rw;
  logic [31:0] d0_addr, d0_wdata;
  logic [15:0] d0_sw;
  logic [31:0] d0_dout;
  logic        d0_ready;
  logic [15:0] d0_led;
  logic        d0_err;
  logic [1:0]  d0_st;

  mio_bus_responder #(.RAM_ADDR_W(RW), .WAIT_CYCLES(W), .LED_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .CPU_MIO(cpu_mio), .MemRW(mem_rw),
    .Addr_in(addr), .Data_in(wdata), .sw_in(sw), .Data_out(dout),
    .MIO_ready(ready), .led_out(led), .bus_err(err), .state_o(st)
  );

  mio_bus_responder #(.RAM_ADDR_W(RW), .WAIT_CYCLES(0), .LED_W(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .CPU_MIO(d0_cpu), .MemRW(d0_rw),
    .Addr_in(d0_addr), .Data_in(d0_wdata), .sw_in(d0_sw), .Data_out(d0_dout),
    .MIO_ready(d0_ready), .led_out(d0_led), .bus_err(d0_err), .state_o(d0_st)
  );

  // Edge count since reset release; edge n leaves the cycle counter at n.
  int cyc;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // ---------------- scoreboard / reference model ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] ram_m [int unsigned];
  int unsigned written_q[$];
  logic [15:0] led_m;
  logic        err_m;
  logic [31:0] dout_m;
  logic [31:0] base_val;
  int          base_cyc;
  logic        cur_wr;
  logic [31:0] cur_addr, cur_data;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    led_m    = 16'h0;
    err_m    = 1'b0;
    dout_m   = 32'h0;
    base_val = 32'h0;
    base_cyc = 0;
    exp_q.delete();
  endtask

  // Apply the committed access to the model; m is the commit edge number.
  task automatic model_commit(input int m);
    int unsigned idx;
    idx = int'(cur_addr[RW+1:2]);
    case (cur_addr[31:28])
      4'h0: begin
        if (cur_wr) begin
          ram_m[idx] = cur_data;
          written_q.push_back(idx);
        end else begin
          dout_m = ram_m[idx];
        end
      end
      4'hE: if (!cur_wr) dout_m = {16'h0, sw};
      4'hF: begin
        if (!cur_addr[2]) begin
          if (cur_wr) led_m = cur_data[15:0];
          else        dout_m = {16'h0, led_m};
        end else begin
          if (cur_wr) begin
            base_val = cur_data;
            base_cyc = m;
          end else begin
            dout_m = base_val + 32'(m - 1 - base_cyc);
          end
        end
      end
      default: begin
        err_m = 1'b1;
        if (!cur_wr) dout_m = 32'h0;
      end
    endcase
    exp_q.push_back(dout_m);
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
    cur_wr   = wr;
    cur_addr = a;
    cur_data = d;
    cpu_mio  = 1'b1;
    mem_rw   = wr;
    addr     = a;
    wdata    = d;
  endtask

  // Waits out the response (bounded), checks latency and results, and returns in
  // the cycle after RESP with CPU_MIO still high so a back-to-back request can follow.
  task automatic complete_req();
    for (int k = 1; k <= W + 1; k++) begin
      @(posedge clk); #1;
      check_eq("ready_latency", {31'b0, ready}, (k == W + 1) ? 32'd1 : 32'd0);
    end
    model_commit(cyc);
    check_eq("data_out", dout, exp_q.pop_front());
    check_eq("led_out", {16'h0, led}, {16'h0, led_m});
    check_eq("bus_err", {31'b0, err}, {31'b0, err_m});
    @(posedge clk); #1;
    check_eq("ready_one_cycle", {31'b0, ready}, 32'd0);
  endtask

  task automatic do_req(input logic wr, input logic [31:0] a, input logic [31:0] d);
    drive_req(wr, a, d);
    complete_req();
  endtask

  task automatic idle(input int n);
    cpu_mio = 1'b0;
    repeat (n) begin
      @(posedge clk); #1;
      check_eq("idle_no_ready", {31'b0, ready}, 32'd0);
    end
  endtask

  task automatic run_random(input int n);
    int          t;
    int          gap;
    int unsigned idx;
    logic [31:0] a;
    logic        wr;
    for (int i = 0; i < n; i++) begin
      t  = $urandom_range(0, 7);
      wr = 1'($urandom);
      case (t)
        0, 1: begin
          idx = $urandom_range(0, (1 << RW) - 1);
          a   = {4'h0, 16'($urandom), 10'(idx), 2'($urandom)};
          do_req(1'b1, a, $urandom);
        end
        2, 3: begin
          idx = written_q[$urandom_range(0, written_q.size() - 1)];
          a   = {4'h0, 16'($urandom), 10'(idx), 2'($urandom)};
          do_req(1'b0, a, $urandom);
        end
        4: do_req(wr, {4'hF, 25'($urandom), 1'b0, 2'($urandom)}, $urandom);
        5: begin
          sw = 16'($urandom);
          do_req(wr, {4'hE, 28'($urandom)}, $urandom);
        end
        6: do_req(($urandom_range(0, 3) == 0), {4'hF, 25'($urandom), 1'b1, 2'($urandom)}, $urandom);
        default: do_req(wr, {4'($urandom_range(1, 13)), 28'($urandom)}, $urandom);
      endcase
      gap = $urandom_range(0, 2);
      if (gap > 0) idle(gap);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    cpu_mio = 1'b0; mem_rw = 1'b0; addr = 32'h0; wdata = 32'h0; sw = 16'h0;
    d0_cpu = 1'b0; d0_rw = 1'b0; d0_addr = 32'h0; d0_wdata = 32'h0; d0_sw = 16'h0;
    cur_wr = 1'b0; cur_addr = 32'h0; cur_data = 32'h0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_data_out", dout, 32'h0);
    check_eq("rst_ready", {31'b0, ready}, 32'd0);
    check_eq("rst_led", {16'h0, led}, 32'h0);
    check_eq("rst_bus_err", {31'b0, err}, 32'd0);
    check_eq("rst_d0_ready", {31'b0, d0_ready}, 32'd0);
    rst_n = 1'b1;

    // RAM write then read back
    do_req(1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    idle(1);
    do_req(1'b0, 32'h0000_0010, 32'h0);
    check_eq("ram_readback_const", dout, 32'hDEAD_BEEF);

    // LED register and switches
    do_req(1'b1, 32'hF000_0000, 32'h0000_1234);
    check_eq("led_const", {16'h0, led}, 32'h0000_1234);
    do_req(1'b0, 32'hF000_0000, 32'h0);
    sw = 16'h00A5;
    do_req(1'b0, 32'hE000_0000, 32'h0);
    check_eq("sw_const", dout, 32'h0000_00A5);

    // Cycle counter load, elapsed count, and wrap
    do_req(1'b1, 32'hF000_0004, 32'h0000_0100);
    do_req(1'b0, 32'hF000_0004, 32'h0);
    check_eq("cnt_after_load_const", dout, 32'h0000_0103);
    do_req(1'b1, 32'hF000_0004, 32'hFFFF_FFFF);
    do_req(1'b0, 32'hF000_0004, 32'h0);
    check_eq("cnt_wrap_const", dout, 32'h0000_0002);

    // Unmapped read sets the sticky error
    idle(2);
    do_req(1'b0, 32'h5000_0000, 32'h0);
    check_eq("unmapped_err_const", {31'b0, err}, 32'd1);

    run_random(80);

    // Abort a write during its wait phase
    idle(1);
    do_req(1'b1, 32'h0000_0020, 32'h1111_2222);
    idle(1);
    drive_req(1'b1, 32'h0000_0020, 32'hBAD0_BAD0);
    @(posedge clk); #1;
    check_eq("abort_wait_ready", {31'b0, ready}, 32'd0);
    cpu_mio = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
      check_eq("abort_no_ready", {31'b0, ready}, 32'd0);
    end
    do_req(1'b0, 32'h0000_0020, 32'h0);
    check_eq("abort_prior_value", dout, 32'h1111_2222);

    // Reset asserted mid-request, then the held request is taken fresh
    idle(1);
    drive_req(1'b1, 32'hF000_0000, 32'h0000_5555);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_ready", {31'b0, ready}, 32'd0);
    check_eq("midrst_led", {16'h0, led}, 32'h0);
    check_eq("midrst_bus_err", {31'b0, err}, 32'd0);
    check_eq("midrst_data_out", dout, 32'h0);
    model_reset();
    @(posedge clk); #1;
    rst_n = 1'b1;
    complete_req();
    do_req(1'b0, 32'hF000_0004, 32'h0);
    run_random(20);

    // Zero-wait-state instance: response in cycle 1
    idle(1);
    d0_cpu = 1'b1; d0_rw = 1'b1; d0_addr = 32'h0000_0040; d0_wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    check_eq("w0_write_ready_c1", {31'b0, d0_ready}, 32'd1);
    @(posedge clk); #1;
    check_eq("w0_ready_one_cycle", {31'b0, d0_ready}, 32'd0);
    d0_rw = 1'b0;
    @(posedge clk); #1;
    check_eq("w0_read_ready_c1", {31'b0, d0_ready}, 32'd1);
    check_eq("w0_read_data", d0_dout, 32'hCAFE_F00D);
    d0_cpu = 1'b0;
    @(posedge clk); #1;
    check_eq("w0_idle_ready", {31'b0, d0_ready}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
